// File: rtl/sprite_shift_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ppu_sprite_pkg
// Description : Shared constants and helpers for the sprite output stage.
// Revision    : 1.0 - initial release
// ============================================================================
package ppu_sprite_pkg;

  localparam int ATTR_PAL_LSB = 0;
  localparam int ATTR_PAL_W   = 2;
  localparam int ATTR_PRIO    = 5;
  localparam int ATTR_HFLIP   = 6;

  localparam int SPR_PIX_W = 4;
  localparam logic [SPR_PIX_W-1:0] SPR_TRANSPARENT = 4'h0;

  function automatic logic [7:0] bit_rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[7-i];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_shift_mux_if.sv
`default_nettype none
// ============================================================================
// Module      : sprite_shift_mux_if
// Description : Control, load and output bundle of the sprite output stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface sprite_shift_mux_if #(
  parameter int N_SLOTS = 8,
  parameter int SLOT_W  = $clog2(N_SLOTS)
);
  import ppu_sprite_pkg::*;

  logic                 pix_en;
  logic                 visible;
  logic [7:0]           pixel_x;
  logic                 sprite_enabled;
  logic                 no_sprite_clip;
  logic                 line_start;
  logic                 load_en;
  logic [SLOT_W-1:0]    load_slot;
  logic [7:0]           load_x;
  logic [7:0]           load_attr;
  logic [7:0]           load_pat_lo;
  logic [7:0]           load_pat_hi;
  logic                 load_is_spr0;
  logic                 bg_opaque;
  logic                 hit_clr;
  logic [SPR_PIX_W-1:0] sprite_pixel;
  logic                 sprite_priority;
  logic                 sprite0_hit;

  modport master (
    output pix_en, visible, pixel_x, sprite_enabled, no_sprite_clip,
           line_start, load_en, load_slot, load_x, load_attr,
           load_pat_lo, load_pat_hi, load_is_spr0, bg_opaque, hit_clr,
    input  sprite_pixel, sprite_priority, sprite0_hit
  );

  modport slave (
    input  pix_en, visible, pixel_x, sprite_enabled, no_sprite_clip,
           line_start, load_en, load_slot, load_x, load_attr,
           load_pat_lo, load_pat_hi, load_is_spr0, bg_opaque, hit_clr,
    output sprite_pixel, sprite_priority, sprite0_hit
  );

endinterface
`default_nettype wire

// File: rtl/sprite_shift_mux_slot.sv
`default_nettype none
// ============================================================================
// Module      : sprite_slot
// Description : One sprite slot: X down-counter, two pattern shifters, flags.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_slot
  import ppu_sprite_pkg::*;
#(
  parameter bit IS_SLOT0 = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 adv_i,
  input  logic                 clr_i,
  input  logic                 load_i,
  input  logic [7:0]           load_x_i,
  input  logic [7:0]           load_attr_i,
  input  logic [7:0]           load_pat_lo_i,
  input  logic [7:0]           load_pat_hi_i,
  input  logic                 load_is_spr0_i,
  output logic [SPR_PIX_W-1:0] pix_o,
  output logic                 opaque_o,
  output logic                 prio_o,
  output logic                 spr0_o
);

  logic                  valid_q, valid_d;
  logic                  spr0_q,  spr0_d;
  logic                  prio_q,  prio_d;
  logic [ATTR_PAL_W-1:0] pal_q,   pal_d;
  logic [7:0]            cnt_q,   cnt_d;
  logic [7:0]            lo_q,    lo_d;
  logic [7:0]            hi_q,    hi_d;
  logic                  w_active;
  logic                  w_attr_unused;

  assign w_attr_unused = ^{load_attr_i[7], load_attr_i[4:2]};
  assign w_active      = (cnt_q == 8'd0);

  always_comb begin
    valid_d = valid_q;
    spr0_d  = spr0_q;
    prio_d  = prio_q;
    pal_d   = pal_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    if (adv_i) begin
      if (!w_active) begin
        cnt_d = cnt_q - 8'd1;
      end else begin
        lo_d = {lo_q[6:0], 1'b0};
        hi_d = {hi_q[6:0], 1'b0};
      end
    end
    if (clr_i) begin
      valid_d = 1'b0;
    end
    // A load overrides both the per-dot advance and a concurrent line clear.
    if (load_i) begin
      valid_d = 1'b1;
      spr0_d  = IS_SLOT0 && load_is_spr0_i;
      prio_d  = load_attr_i[ATTR_PRIO];
      pal_d   = load_attr_i[ATTR_PAL_LSB +: ATTR_PAL_W];
      cnt_d   = load_x_i;
      lo_d    = load_attr_i[ATTR_HFLIP] ? bit_rev8(load_pat_lo_i) : load_pat_lo_i;
      hi_d    = load_attr_i[ATTR_HFLIP] ? bit_rev8(load_pat_hi_i) : load_pat_hi_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      spr0_q  <= 1'b0;
      prio_q  <= 1'b0;
      pal_q   <= '0;
      cnt_q   <= 8'd0;
      lo_q    <= 8'd0;
      hi_q    <= 8'd0;
    end else begin
      valid_q <= valid_d;
      spr0_q  <= spr0_d;
      prio_q  <= prio_d;
      pal_q   <= pal_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  assign pix_o    = {pal_q, hi_q[7], lo_q[7]};
  assign opaque_o = valid_q && w_active && (hi_q[7] || lo_q[7]);
  assign prio_o   = prio_q;
  assign spr0_o   = valid_q && spr0_q;

endmodule
`default_nettype wire

// File: rtl/sprite_shift_mux.sv
`default_nettype none
// ============================================================================
// Module      : sprite_shift_mux
// Description : Per-scanline sprite serialiser, priority select and 0-hit.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_shift_mux
  import ppu_sprite_pkg::*;
#(
  parameter int N_SLOTS = 8,
  parameter int SLOT_W  = $clog2(N_SLOTS)
) (
  input  logic              clk,
  input  logic              rst,
  sprite_shift_mux_if.slave spr_if
);

  logic                 w_adv;
  logic                 w_clr;
  logic                 w_forced;
  logic                 w_spr0_hit;
  logic [N_SLOTS-1:0]   w_opaque;
  logic [N_SLOTS-1:0]   w_prio;
  logic [N_SLOTS-1:0]   w_spr0;
  logic [SPR_PIX_W-1:0] w_pix [N_SLOTS];
  logic                 w_win_found;
  logic [SPR_PIX_W-1:0] w_win_pix;
  logic                 w_win_prio;

  logic [SPR_PIX_W-1:0] pix_q, pix_d;
  logic                 prio_q, prio_d;
  logic                 hit_q, hit_d;

  assign w_adv = spr_if.pix_en && spr_if.visible;
  assign w_clr = spr_if.pix_en && spr_if.line_start;

  // Out-of-range load_slot values match no slot, so such loads are dropped.
  generate
    for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
      sprite_slot #(
        .IS_SLOT0 (g == 0)
      ) u_slot (
        .clk            (clk),
        .rst            (rst),
        .adv_i          (w_adv),
        .clr_i          (w_clr),
        .load_i         (spr_if.load_en && (spr_if.load_slot == SLOT_W'(g))),
        .load_x_i       (spr_if.load_x),
        .load_attr_i    (spr_if.load_attr),
        .load_pat_lo_i  (spr_if.load_pat_lo),
        .load_pat_hi_i  (spr_if.load_pat_hi),
        .load_is_spr0_i (spr_if.load_is_spr0),
        .pix_o          (w_pix[g]),
        .opaque_o       (w_opaque[g]),
        .prio_o         (w_prio[g]),
        .spr0_o         (w_spr0[g])
      );
    end
  endgenerate

  // Scan from the highest index down so the lowest opaque index is kept last.
  always_comb begin
    w_win_found = 1'b0;
    w_win_pix   = SPR_TRANSPARENT;
    w_win_prio  = 1'b1;
    for (int s = N_SLOTS - 1; s >= 0; s--) begin
      if (w_opaque[s]) begin
        w_win_found = 1'b1;
        w_win_pix   = w_pix[s];
        w_win_prio  = w_prio[s];
      end
    end
  end

  // Only slot 0 can carry the sprite-0 flag, regardless of who wins the pixel.
  assign w_spr0_hit = |(w_spr0 & w_opaque);
  assign w_forced   = !spr_if.sprite_enabled ||
                      (!spr_if.no_sprite_clip && (spr_if.pixel_x < 8'd8));

  always_comb begin
    pix_d  = pix_q;
    prio_d = prio_q;
    hit_d  = hit_q;
    if (spr_if.pix_en) begin
      if (spr_if.visible && !w_forced && w_win_found) begin
        pix_d  = w_win_pix;
        prio_d = w_win_prio;
      end else begin
        pix_d  = SPR_TRANSPARENT;
        prio_d = 1'b1;
      end
      if (spr_if.visible && w_spr0_hit && spr_if.bg_opaque && !w_forced &&
          (spr_if.pixel_x != 8'd255)) begin
        hit_d = 1'b1;
      end
    end
    if (spr_if.hit_clr) begin
      hit_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_q  <= SPR_TRANSPARENT;
      prio_q <= 1'b1;
      hit_q  <= 1'b0;
    end else begin
      pix_q  <= pix_d;
      prio_q <= prio_d;
      hit_q  <= hit_d;
    end
  end

  assign spr_if.sprite_pixel    = pix_q;
  assign spr_if.sprite_priority = prio_q;
  assign spr_if.sprite0_hit     = hit_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_shift_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_shift_mux
// Description : Bench for sprite_shift_mux, 8-slot and 16-slot instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_shift_mux;

  logic       clk;
  logic       rst;
  logic       pix_en, visible, sprite_enabled, no_sprite_clip, line_start;
  logic [7:0] pixel_x;
  logic       load_en, load_is_spr0, bg_opaque, hit_clr;
  logic [3:0] load_slot;
  logic [7:0] load_x, load_attr, load_pat_lo, load_pat_hi;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  sprite_shift_mux_if #(.N_SLOTS(8))  ifa ();
  sprite_shift_mux_if #(.N_SLOTS(16)) ifb ();

  assign ifa.pix_en = pix_en;                 assign ifb.pix_en = pix_en;
  assign ifa.visible = visible;               assign ifb.visible = visible;
  assign ifa.pixel_x = pixel_x;               assign ifb.pixel_x = pixel_x;
  assign ifa.sprite_enabled = sprite_enabled; assign ifb.sprite_enabled = sprite_enabled;
  assign ifa.no_sprite_clip = no_sprite_clip; assign ifb.no_sprite_clip = no_sprite_clip;
  assign ifa.line_start = line_start;         assign ifb.line_start = line_start;
  assign ifa.load_en = load_en && (load_slot < 4'd8);
  assign ifb.load_en = load_en;
  assign ifa.load_slot = load_slot[2:0];      assign ifb.load_slot = load_slot;
  assign ifa.load_x = load_x;                 assign ifb.load_x = load_x;
  assign ifa.load_attr = load_attr;           assign ifb.load_attr = load_attr;
  assign ifa.load_pat_lo = load_pat_lo;       assign ifb.load_pat_lo = load_pat_lo;
  assign ifa.load_pat_hi = load_pat_hi;       assign ifb.load_pat_hi = load_pat_hi;
  assign ifa.load_is_spr0 = load_is_spr0;     assign ifb.load_is_spr0 = load_is_spr0;
  assign ifa.bg_opaque = bg_opaque;           assign ifb.bg_opaque = bg_opaque;
  assign ifa.hit_clr = hit_clr;               assign ifb.hit_clr = hit_clr;

  sprite_shift_mux #(.N_SLOTS(8))  u_dut8  (.clk(clk), .rst(rst), .spr_if(ifa.slave));
  sprite_shift_mux #(.N_SLOTS(16)) u_dut16 (.clk(clk), .rst(rst), .spr_if(ifb.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: each slot remembers how many visible dots have elapsed
  // since it was loaded; pattern column = elapsed - X, shown when in 0..7.
  bit         m_valid [2][16];
  int         m_x     [2][16];
  int         m_n     [2][16];
  logic [1:0] m_pal   [2][16];
  bit         m_prio  [2][16];
  bit         m_spr0  [2][16];
  logic [7:0] m_lo    [2][16];
  logic [7:0] m_hi    [2][16];
  logic [3:0] e_pix   [2];
  bit         e_prio  [2];
  bit         e_hit   [2];

  function automatic int ns(input int m);
    return (m == 0) ? 8 : 16;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = v[7-k];
    return r;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int s = 0; s < 16; s++) begin
        m_valid[m][s] = 0; m_x[m][s] = 0; m_n[m][s] = 0; m_pal[m][s] = 0;
        m_prio[m][s] = 0; m_spr0[m][s] = 0; m_lo[m][s] = 0; m_hi[m][s] = 0;
      end
      e_pix[m] = 4'h0; e_prio[m] = 1; e_hit[m] = 0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      int         win;
      bit         hsrc, forced;
      logic [3:0] wpix;
      bit         wprio;
      win = -1; hsrc = 0; wpix = 4'h0; wprio = 1;
      forced = !sprite_enabled || (!no_sprite_clip && pixel_x < 8);
      for (int s = 0; s < ns(m); s++) begin
        int col;
        bit lb, hb;
        col = m_n[m][s] - m_x[m][s];
        if (m_valid[m][s] && col >= 0 && col < 8) begin
          lb = m_lo[m][s][7-col];
          hb = m_hi[m][s][7-col];
          if (lb || hb) begin
            if (win < 0) begin
              win = s; wpix = {m_pal[m][s], hb, lb}; wprio = m_prio[m][s];
            end
            if (s == 0 && m_spr0[m][0]) hsrc = 1;
          end
        end
      end
      if (pix_en) begin
        if (visible && !forced && win >= 0) begin
          e_pix[m] = wpix; e_prio[m] = wprio;
        end else begin
          e_pix[m] = 4'h0; e_prio[m] = 1;
        end
        if (visible && hsrc && bg_opaque && !forced && pixel_x != 8'd255) e_hit[m] = 1;
      end
      if (hit_clr) e_hit[m] = 0;
      if (pix_en && visible) for (int s = 0; s < 16; s++) m_n[m][s]++;
      if (pix_en && line_start) for (int s = 0; s < 16; s++) m_valid[m][s] = 0;
      if (load_en && int'(load_slot) < ns(m)) begin
        m_valid[m][load_slot] = 1;
        m_x[m][load_slot]     = int'(load_x);
        m_n[m][load_slot]     = 0;
        m_pal[m][load_slot]   = load_attr[1:0];
        m_prio[m][load_slot]  = load_attr[5];
        m_spr0[m][load_slot]  = (load_slot == 4'd0) && load_is_spr0;
        m_lo[m][load_slot]    = load_attr[6] ? rev8(load_pat_lo) : load_pat_lo;
        m_hi[m][load_slot]    = load_attr[6] ? rev8(load_pat_hi) : load_pat_hi;
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: actual %0h required %0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("n8.pix",   int'(ifa.sprite_pixel),    int'(e_pix[0]));
    chk("n8.prio",  int'(ifa.sprite_priority), int'(e_prio[0]));
    chk("n8.hit",   int'(ifa.sprite0_hit),     int'(e_hit[0]));
    chk("n16.pix",  int'(ifb.sprite_pixel),    int'(e_pix[1]));
    chk("n16.prio", int'(ifb.sprite_priority), int'(e_prio[1]));
    chk("n16.hit",  int'(ifb.sprite0_hit),     int'(e_hit[1]));
  endtask

  task automatic do_line_start();
    pix_en = 1; visible = 0; line_start = 1;
    tick();
    line_start = 0; pix_en = 0;
  endtask

  task automatic do_load(input int slot, input int x, input logic [7:0] attr,
                         input logic [7:0] lo, input logic [7:0] hi, input bit s0);
    pix_en = 0; visible = 0;
    load_en = 1; load_slot = 4'(slot); load_x = 8'(x); load_attr = attr;
    load_pat_lo = lo; load_pat_hi = hi; load_is_spr0 = s0;
    tick();
    load_en = 0;
  endtask

  task automatic dot(input int d);
    pix_en = 1; visible = 1; pixel_x = 8'(d);
    tick();
  endtask

  typedef struct {
    int         dot;
    logic [3:0] pix;
    bit         prio;
  } vec_t;

  vec_t tbl [20];

  initial begin
    for (int d = 0; d < 20; d++) begin
      tbl[d].dot  = d;
      tbl[d].pix  = (d >= 10 && d <= 17) ? 4'h9 : 4'h0;
      tbl[d].prio = !(d >= 10 && d <= 17);
    end

    rst = 0; pix_en = 0; visible = 0; pixel_x = 0; sprite_enabled = 1;
    no_sprite_clip = 1; line_start = 0; load_en = 0; load_slot = 0; load_x = 0;
    load_attr = 0; load_pat_lo = 0; load_pat_hi = 0; load_is_spr0 = 0;
    bg_opaque = 0; hit_clr = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1;
    chk("reset.pix",  int'(ifa.sprite_pixel),    0);
    chk("reset.prio", int'(ifa.sprite_priority), 1);
    chk("reset.hit",  int'(ifa.sprite0_hit),     0);
    tick();

    // Single sprite, table-driven expectations
    do_line_start();
    do_load(0, 10, 8'h02, 8'hFF, 8'h00, 0);
    for (int k = 0; k < 20; k++) begin
      dot(tbl[k].dot);
      chk("tbl.pix",  int'(ifa.sprite_pixel),    int'(tbl[k].pix));
      chk("tbl.prio", int'(ifa.sprite_priority), int'(tbl[k].prio));
      chk("tbl.pix16", int'(ifb.sprite_pixel),   int'(tbl[k].pix));
    end

    // Overlap: slot 0 transparent for its first four columns
    do_line_start();
    do_load(0, 20, 8'h01, 8'h0F, 8'h00, 0);
    do_load(3, 20, 8'h03, 8'hFF, 8'hFF, 0);
    for (int d = 0; d < 28; d++) begin
      dot(d);
      if (d >= 20) chk("ovl.pix", int'(ifa.sprite_pixel), (d < 24) ? 'hF : 'h5);
    end

    // Horizontal flip at X=0, with and without left clipping
    bg_opaque = 1;
    do_line_start();
    do_load(0, 0, 8'h40, 8'h01, 8'h00, 1);
    dot(0);
    chk("flip.pix0", int'(ifa.sprite_pixel), 1);
    chk("flip.hit0", int'(ifa.sprite0_hit),  1);
    dot(1);
    chk("flip.pix1", int'(ifa.sprite_pixel), 0);
    pix_en = 0; hit_clr = 1; tick(); hit_clr = 0;
    chk("flip.clr", int'(ifa.sprite0_hit), 0);
    no_sprite_clip = 0;
    do_line_start();
    do_load(0, 0, 8'h40, 8'h01, 8'h00, 1);
    for (int d = 0; d < 8; d++) begin
      dot(d);
      chk("clip.pix", int'(ifa.sprite_pixel), 0);
      chk("clip.hit", int'(ifa.sprite0_hit),  0);
    end
    no_sprite_clip = 1;

    // Sprite-0 at X=255 never hits
    do_line_start();
    do_load(0, 255, 8'h00, 8'hFF, 8'h00, 1);
    for (int d = 0; d < 256; d++) dot(d);
    chk("x255.pix", int'(ifa.sprite_pixel), 1);
    chk("x255.hit", int'(ifa.sprite0_hit),  0);

    // Sprite-0 at X=100: sticky hit, clear wins over a coincident hit
    do_line_start();
    do_load(0, 100, 8'h00, 8'hFF, 8'h00, 1);
    for (int d = 0; d < 100; d++) dot(d);
    chk("h100.pre", int'(ifa.sprite0_hit), 0);
    dot(100);
    chk("h100.set", int'(ifa.sprite0_hit), 1);
    bg_opaque = 0;
    dot(101);
    chk("h100.sticky", int'(ifa.sprite0_hit), 1);
    bg_opaque = 1; hit_clr = 1;
    dot(102);
    hit_clr = 0;
    chk("h100.clrwins", int'(ifa.sprite0_hit), 0);
    dot(103);
    chk("h100.reset", int'(ifa.sprite0_hit), 1);

    // Asynchronous reset mid-line with slots loaded
    #2 rst = 0;
    #1;
    chk("arst.pix",  int'(ifa.sprite_pixel),    0);
    chk("arst.prio", int'(ifa.sprite_priority), 1);
    chk("arst.hit",  int'(ifa.sprite0_hit),     0);
    chk("arst.hit16", int'(ifb.sprite0_hit),    0);
    model_reset();
    @(negedge clk);
    rst = 1;
    for (int d = 104; d < 110; d++) begin
      dot(d);
      chk("arst.inval", int'(ifa.sprite_pixel), 0);
    end

    // 16 slots: slot 15 wins alone; load alongside line_start
    do_line_start();
    do_load(2, 5, 8'h03, 8'hFF, 8'hFF, 0);
    do_load(14, 5, 8'h02, 8'hFF, 8'h00, 0);
    pix_en = 1; visible = 0; line_start = 1;
    load_en = 1; load_slot = 4'd15; load_x = 8'd5; load_attr = 8'h01;
    load_pat_lo = 8'hFF; load_pat_hi = 8'h00; load_is_spr0 = 0;
    tick();
    line_start = 0; load_en = 0;
    for (int d = 0; d < 8; d++) dot(d);
    chk("n16.slot15", int'(ifb.sprite_pixel), 5);
    chk("n8.cleared", int'(ifa.sprite_pixel), 0);

    // Randomised scanlines against the model
    for (int line = 0; line < 24; line++) begin
      sprite_enabled = ($urandom % 8) != 0;
      no_sprite_clip = $urandom % 2;
      pix_en = 1; visible = 0; line_start = 1;
      if ($urandom % 3 == 0) begin
        load_en = 1; load_slot = 4'($urandom); load_x = 8'($urandom);
        load_attr = 8'($urandom); load_pat_lo = 8'($urandom);
        load_pat_hi = 8'($urandom); load_is_spr0 = $urandom % 2;
      end
      tick();
      line_start = 0; load_en = 0;
      for (int k = 0, nl = $urandom_range(0, 12); k < nl; k++) begin
        int x;
        x = ($urandom % 4 == 0) ? $urandom_range(249, 255) : $urandom_range(0, 255);
        pix_en = $urandom % 2;
        load_en = 1; load_slot = 4'($urandom); load_x = 8'(x);
        load_attr = 8'($urandom); load_pat_lo = 8'($urandom);
        load_pat_hi = ($urandom % 2) ? 8'($urandom) : 8'h00;
        load_is_spr0 = ($urandom % 4) != 0;
        tick();
        load_en = 0;
      end
      begin
        int d;
        d = 0;
        while (d < 256) begin
          pix_en = ($urandom % 4) != 0; visible = 1; pixel_x = 8'(d);
          bg_opaque = $urandom % 2;
          hit_clr = ($urandom % 128) == 0;
          if ($urandom % 64 == 0) begin
            load_en = 1; load_slot = 4'($urandom); load_x = 8'($urandom);
            load_attr = 8'($urandom); load_pat_lo = 8'($urandom);
            load_pat_hi = 8'($urandom); load_is_spr0 = $urandom % 2;
          end
          tick();
          load_en = 0; hit_clr = 0;
          if (pix_en) d++;
        end
      end
      visible = 0;
      for (int k = 0; k < 6; k++) begin
        pix_en = $urandom % 2;
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
